// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op codes, FSM state encoding and iteration count for muldiv_unit
package muldiv_pkg;
  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_MULH = 2'b01;
  localparam logic [1:0] OP_DIVU = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;
  localparam logic [4:0] ITER_LAST = 5'd15;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request and register-file write port bundle of muldiv_unit
interface muldiv_unit_if #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 3
);
  logic              start;
  logic [1:0]        op;
  logic [ADDR_W-1:0] dest;
  logic [WIDTH-1:0]  Adata;
  logic [WIDTH-1:0]  Bdata;
  logic              busy;
  logic              done;
  logic              WE;
  logic [ADDR_W-1:0] Waddr;
  logic [WIDTH-1:0]  Wdata;
  modport master (output start, op, dest, Adata, Bdata, input busy, done, WE, Waddr, Wdata);
  modport slave  (input start, op, dest, Adata, Bdata, output busy, done, WE, Waddr, Wdata);
endinterface

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: IDLE/CALC/DONE sequencer and iteration counter; MULDIV_EARLY_EXIT_EN ends multiplies once the multiplier is exhausted
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk_n,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_mul,
  input  logic [WIDTH-1:0] mplier,
  output logic             cap,
  output logic             step,
  output logic             last,
  output logic             busy,
  output logic             done,
  output logic [4:0]       cnt
);
  state_t     state, state_nx;
  logic [4:0] cnt_nx;
`ifdef MULDIV_EARLY_EXIT_EN
  logic [WIDTH-1:0] rest;
  assign rest = mplier >> (cnt + 5'd1);
  assign last = cnt == ITER_LAST || (is_mul && rest == '0);
`else
  logic unused_early;
  assign unused_early = is_mul | (|mplier);
  assign last = cnt == ITER_LAST;
`endif
  assign cap  = state == ST_IDLE && start;
  assign step = state == ST_CALC;
  assign busy = state != ST_IDLE;
  assign done = state == ST_DONE;
  // state and iteration counter registers
  always_ff @(posedge clk_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end
  // next state: start only accepted in IDLE, DONE lasts a single cycle
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    state_nx = cap ? ST_CALC : (step && last) ? ST_DONE : done ? ST_IDLE : state;
    cnt_nx   = cap ? 5'd0 : step ? cnt + 5'd1 : cnt;
  end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative shift-add multiply / restoring divide writing the register file; MULDIV_EARLY_EXIT_EN shortens multiplies
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 3
) (
  input logic          clk_n,
  input logic          rst_n,
  muldiv_unit_if.slave bus
);
  logic [WIDTH-1:0]   hi, lo, a, b, rdiff;
  logic [1:0]         op_q;
  logic [ADDR_W-1:0]  dest_q;
  logic [WIDTH:0]     sum, shl;
  logic [2*WIDTH-1:0] prod;
  logic               neg, cap, step, last, busy, done;
  logic [4:0]         cnt;
  muldiv_ctrl #(.WIDTH(WIDTH)) u_ctrl (
    .clk_n (clk_n),
    .rst_n (rst_n),
    .start (bus.start),
    .is_mul(~op_q[1]),
    .mplier(b),
    .cap   (cap),
    .step  (step),
    .last  (last),
    .busy  (busy),
    .done  (done),
    .cnt   (cnt)
  );
  // one iteration of each algorithm; on the final multiply step the skipped shifts are folded in
  always_comb begin
    sum   = {1'b0, hi} + (lo[0] ? {1'b0, a} : '0);
    prod  = {sum, lo[WIDTH-1:1]} >> (last ? ITER_LAST - cnt : 5'd0);
    shl   = {hi, lo[WIDTH-1]};
    neg   = shl < {1'b0, b};
    rdiff = shl[WIDTH-1:0] - b;
  end
  // operand capture and product/remainder-quotient registers
  always_ff @(posedge clk_n) begin
    if (!rst_n) begin
      {hi, lo, a, b, op_q, dest_q} <= '0;
    end else if (cap) begin
      a      <= bus.Adata;
      b      <= bus.Bdata;
      op_q   <= bus.op;
      dest_q <= bus.dest;
      hi     <= '0;
      lo     <= bus.op[1] ? bus.Adata : bus.Bdata;
    end else if (step) begin
      hi <= op_q[1] ? (neg ? shl[WIDTH-1:0] : rdiff) : prod[2*WIDTH-1:WIDTH];
      lo <= op_q[1] ? {lo[WIDTH-2:0], ~neg} : prod[WIDTH-1:0];
    end
  end
  assign bus.busy  = busy;
  assign bus.done  = done;
  assign bus.WE    = done;
  assign bus.Waddr = dest_q;
  assign bus.Wdata = done ? (op_q[0] ? hi : lo) : '0;
endmodule
